// File: rtl/regfile_pkg.sv
// Shared constants and enums for the register-file write-port scheduler.
// Widths here set the defaults used by the scheduler's parameters.
package regfile_pkg;
   localparam int NUM_REGS = 8;
   localparam int REG_ID_W = 3;
   localparam int DATA_W   = 8;

   typedef enum logic {ST_INIT, ST_RUN} state_t;
   typedef enum logic {SEL_A, SEL_B} sel_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational; one-hot o_grant, bit 0 = A.
// A lone valid always wins, and prio breaks ties. Nothing is granted while i_enable is low.
module rr_arb2
   import regfile_pkg::*;
(
   input  logic       i_a_valid,
   input  logic       i_b_valid,
   input  sel_t       i_prio,
   input  logic       i_enable,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = 2'b00;
      if (i_enable) begin
         if (i_a_valid && (!i_b_valid || i_prio == SEL_A)) begin
            o_grant = 2'b01;
         end else if (i_b_valid) begin
            o_grant = 2'b10;
         end
      end
   end

endmodule

// File: rtl/regfile_write_sched.sv
// Zero-sweeps the register file and then round-robins two writers onto its single write port.
// An accept in cycle n drives the write strobe in cycle n+1. Readies stay low during the sweep and in a clear cycle.
module regfile_write_sched #(
   parameter int NUM_REGS = 8,
   parameter int REG_ID_W = 3,
   parameter int DATA_W   = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic [REG_ID_W-1:0] a_reg_id,
   input  logic [DATA_W-1:0]   a_reg_val,
   input  logic                b_valid,
   output logic                b_ready,
   input  logic [REG_ID_W-1:0] b_reg_id,
   input  logic [DATA_W-1:0]   b_reg_val,
   output logic                rf_write_enable,
   output logic [REG_ID_W-1:0] rf_write_reg_id,
   output logic [DATA_W-1:0]   rf_write_reg_val,
   output logic                init_done
);
   import regfile_pkg::*;

   state_t              r_state;
   state_t              w_next_state;
   sel_t                r_prio;
   sel_t                w_next_prio;
   logic [REG_ID_W-1:0] r_sweep_cnt;
   logic                r_wr_en;
   logic [REG_ID_W-1:0] r_wr_id;
   logic [DATA_W-1:0]   r_wr_val;
   logic                r_init_done;

   logic [1:0]          w_grant;
   logic                w_arb_en;
   logic                w_sweep_last;
   logic                w_a_ready;
   logic                w_b_ready;
   logic                w_load_en;
   logic [REG_ID_W-1:0] w_load_id;
   logic [DATA_W-1:0]   w_load_val;

   // A clear cycle grants nothing, so a requester simply keeps valid up across the sweep.
   assign w_arb_en     = (r_state == ST_RUN) && !clear;
   assign w_sweep_last = (r_sweep_cnt == REG_ID_W'(NUM_REGS - 1));

   rr_arb2 u_arb (
      .i_a_valid (a_valid),
      .i_b_valid (b_valid),
      .i_prio    (r_prio),
      .i_enable  (w_arb_en),
      .o_grant   (w_grant)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_INIT: if (w_sweep_last) w_next_state = ST_RUN;
         ST_RUN:  if (clear)        w_next_state = ST_INIT;
         default: w_next_state = ST_INIT;
      endcase
   end

   always_comb begin
      w_a_ready   = 1'b0;
      w_b_ready   = 1'b0;
      w_load_en   = 1'b0;
      w_load_id   = r_wr_id;
      w_load_val  = r_wr_val;
      w_next_prio = r_prio;
      case (r_state)
         ST_INIT: begin
            w_load_en  = 1'b1;
            w_load_id  = r_sweep_cnt;
            w_load_val = '0;
         end
         ST_RUN: begin
            w_a_ready = w_grant[0];
            w_b_ready = w_grant[1];
            if (w_grant[0]) begin
               w_load_en   = 1'b1;
               w_load_id   = a_reg_id;
               w_load_val  = a_reg_val;
               w_next_prio = SEL_B;
            end else if (w_grant[1]) begin
               w_load_en   = 1'b1;
               w_load_id   = b_reg_id;
               w_load_val  = b_reg_val;
               w_next_prio = SEL_A;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sweep_cnt <= '0;
         r_prio      <= SEL_A;
         r_wr_en     <= 1'b0;
         r_wr_id     <= '0;
         r_wr_val    <= '0;
         r_init_done <= 1'b0;
      end else begin
         if (r_state == ST_INIT && !w_sweep_last) begin
            r_sweep_cnt <= r_sweep_cnt + 1'b1;
         end else begin
            r_sweep_cnt <= '0;
         end
         r_prio      <= w_next_prio;
         r_wr_en     <= w_load_en;
         r_wr_id     <= w_load_id;
         r_wr_val    <= w_load_val;
         r_init_done <= (w_next_state == ST_RUN);
      end
   end

   assign a_ready          = w_a_ready;
   assign b_ready          = w_b_ready;
   assign rf_write_enable  = r_wr_en;
   assign rf_write_reg_id  = r_wr_id;
   assign rf_write_reg_val = r_wr_val;
   assign init_done        = r_init_done;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched: sweep, single writes, alternation, same-id ordering, clear and mid-sweep reset.
module tb_regfile_write_sched;

   logic       clk = 1'b0;
   logic       reset, clear;
   logic       a_valid, a_ready, b_valid, b_ready;
   logic [2:0] a_reg_id, b_reg_id, rf_write_reg_id;
   logic [7:0] a_reg_val, b_reg_val, rf_write_reg_val;
   logic       rf_write_enable, init_done;

   logic [7:0] rf_model [8];
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   regfile_write_sched dut (
      .clk              (clk),
      .reset            (reset),
      .clear            (clear),
      .a_valid          (a_valid),
      .a_ready          (a_ready),
      .a_reg_id         (a_reg_id),
      .a_reg_val        (a_reg_val),
      .b_valid          (b_valid),
      .b_ready          (b_ready),
      .b_reg_id         (b_reg_id),
      .b_reg_val        (b_reg_val),
      .rf_write_enable  (rf_write_enable),
      .rf_write_reg_id  (rf_write_reg_id),
      .rf_write_reg_val (rf_write_reg_val),
      .init_done        (init_done)
   );

   // Register-file model captures the write strobe at each rising edge.
   initial for (int i = 0; i < 8; i++) rf_model[i] = 8'h5A;
   always @(posedge clk) if (rf_write_enable) rf_model[rf_write_reg_id] <= rf_write_reg_val;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Outputs checked as one vector {en, id, val}.
   task automatic chk_wr(input string tag, input logic en, input logic [2:0] id, input logic [7:0] val);
      chk(tag, {4'h0, rf_write_enable, rf_write_reg_id, rf_write_reg_val}, {4'h0, en, id, val});
   endtask

   task automatic next_cyc;
      @(posedge clk);
      #2;
   endtask

   task automatic settle;
      #2;
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0;
      a_valid = 1'b0; a_reg_id = 3'd0; a_reg_val = 8'h00;
      b_valid = 1'b0; b_reg_id = 3'd0; b_reg_val = 8'h00;
      repeat (3) @(posedge clk);

      // Sweep after reset; both requesters pending and a clear pulse must all be ignored.
      for (int k = 0; k < 10; k++) begin
         next_cyc();
         reset     = 1'b0;
         a_valid   = (k < 8);
         b_valid   = (k < 8);
         a_reg_id  = 3'd6; a_reg_val = 8'hE6;
         b_reg_id  = 3'd7; b_reg_val = 8'hE7;
         clear     = (k == 3);
         settle();
         chk("sweep_a_ready", {15'd0, a_ready}, 16'd0 + ((k == 8) ? 16'd0 : 16'd0));
         chk("sweep_b_ready", {15'd0, b_ready}, 16'd0);
         chk("sweep_init_done", {15'd0, init_done}, {15'd0, (k >= 8)});
         if (k == 0)      chk_wr("sweep_reset_out", 1'b0, 3'd0, 8'h00);
         else if (k <= 8) chk_wr("sweep_write", 1'b1, 3'(k - 1), 8'h00);
         else             chk_wr("sweep_idle", 1'b0, 3'd7, 8'h00);
      end
      clear = 1'b0;
      for (int i = 0; i < 8; i++) chk("sweep_model", {8'h0, rf_model[i]}, 16'h0000);

      // Single A write, then single B write to restore prio=A.
      next_cyc();
      a_valid = 1'b1; a_reg_id = 3'd3; a_reg_val = 8'hFF;
      settle();
      chk("a_alone_ready", {14'd0, b_ready, a_ready}, 16'b01);
      next_cyc();
      a_valid = 1'b0;
      settle();
      chk_wr("a_alone_write", 1'b1, 3'd3, 8'hFF);
      chk("a_alone_ready_drop", {15'd0, a_ready}, 16'd0);
      next_cyc();
      b_valid = 1'b1; b_reg_id = 3'd6; b_reg_val = 8'h66;
      settle();
      chk_wr("a_alone_after", 1'b0, 3'd3, 8'hFF);
      chk("b_alone_ready", {14'd0, b_ready, a_ready}, 16'b10);
      next_cyc();
      b_valid = 1'b0;
      settle();
      chk_wr("b_alone_write", 1'b1, 3'd6, 8'h66);

      // Both valid for four grants with prio=A: A, B, A, B.
      next_cyc();
      a_valid = 1'b1; a_reg_id = 3'd1; a_reg_val = 8'h11;
      b_valid = 1'b1; b_reg_id = 3'd2; b_reg_val = 8'h22;
      settle();
      chk_wr("alt_idle", 1'b0, 3'd6, 8'h66);
      chk("alt_grant0", {14'd0, b_ready, a_ready}, 16'b01);
      next_cyc(); settle();
      chk("alt_grant1", {14'd0, b_ready, a_ready}, 16'b10);
      chk_wr("alt_out0", 1'b1, 3'd1, 8'h11);
      next_cyc(); settle();
      chk("alt_grant2", {14'd0, b_ready, a_ready}, 16'b01);
      chk_wr("alt_out1", 1'b1, 3'd2, 8'h22);
      next_cyc(); settle();
      chk("alt_grant3", {14'd0, b_ready, a_ready}, 16'b10);
      chk_wr("alt_out2", 1'b1, 3'd1, 8'h11);
      next_cyc();
      b_valid = 1'b0;
      a_reg_id = 3'd0; a_reg_val = 8'h01;
      settle();
      chk_wr("alt_out3", 1'b1, 3'd2, 8'h22);
      chk("prio_a_after_alt", {14'd0, b_ready, a_ready}, 16'b01);
      next_cyc();
      a_valid = 1'b0;
      settle();
      chk_wr("prio_flip_write", 1'b1, 3'd0, 8'h01);

      // Same register from both sides with prio=B: B first, then A wins the file.
      next_cyc();
      a_valid = 1'b1; a_reg_id = 3'd5; a_reg_val = 8'hAA;
      b_valid = 1'b1; b_reg_id = 3'd5; b_reg_val = 8'hBB;
      settle();
      chk("same_id_first", {14'd0, b_ready, a_ready}, 16'b10);
      next_cyc();
      b_valid = 1'b0;
      settle();
      chk("same_id_second", {14'd0, b_ready, a_ready}, 16'b01);
      chk_wr("same_id_out_b", 1'b1, 3'd5, 8'hBB);
      next_cyc();
      a_valid = 1'b0;
      settle();
      chk_wr("same_id_out_a", 1'b1, 3'd5, 8'hAA);
      next_cyc(); settle();
      chk_wr("same_id_idle", 1'b0, 3'd5, 8'hAA);
      chk("model_r5", {8'h0, rf_model[5]}, 16'h00AA);
      chk("model_r3", {8'h0, rf_model[3]}, 16'h00FF);
      chk("model_r1", {8'h0, rf_model[1]}, 16'h0011);
      chk("model_r2", {8'h0, rf_model[2]}, 16'h0022);

      // clear together with a_valid: no accept, full re-sweep, accept in the first RUN cycle.
      next_cyc();
      a_valid = 1'b1; a_reg_id = 3'd4; a_reg_val = 8'h44;
      clear = 1'b1;
      settle();
      chk("clear_no_ready", {14'd0, b_ready, a_ready}, 16'b00);
      for (int k = 0; k <= 8; k++) begin
         next_cyc();
         clear = 1'b0;
         settle();
         chk("clear_init_done", {15'd0, init_done}, {15'd0, (k == 8)});
         chk("clear_a_ready", {15'd0, a_ready}, {15'd0, (k == 8)});
         if (k == 0) chk_wr("clear_first", 1'b0, 3'd5, 8'hAA);
         else        chk_wr("clear_sweep", 1'b1, 3'(k - 1), 8'h00);
      end
      next_cyc();
      a_valid = 1'b0;
      settle();
      chk_wr("clear_accept_out", 1'b1, 3'd4, 8'h44);
      chk("clear_model_r5", {8'h0, rf_model[5]}, 16'h0000);

      // Reset while sweep_cnt == 4.
      next_cyc();
      clear = 1'b1;
      settle();
      next_cyc();
      clear = 1'b0;
      settle();
      chk_wr("rst_sweep0", 1'b0, 3'd4, 8'h44);
      for (int k = 1; k <= 3; k++) begin next_cyc(); settle(); end
      next_cyc();
      reset = 1'b1;
      settle();
      chk_wr("rst_sweep4", 1'b1, 3'd3, 8'h00);
      next_cyc();
      reset = 1'b0;
      settle();
      chk_wr("rst_applied", 1'b0, 3'd0, 8'h00);
      chk("rst_init_done", {15'd0, init_done}, 16'd0);
      next_cyc(); settle();
      chk_wr("rst_restart0", 1'b1, 3'd0, 8'h00);
      next_cyc(); settle();
      chk_wr("rst_restart1", 1'b1, 3'd1, 8'h00);

      begin
         int budget = 20;
         while (!init_done && budget > 0) begin
            next_cyc(); settle();
            budget--;
         end
         chk("rst_reaches_run", {15'd0, init_done}, 16'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_write_sched.md
# regfile_write_sched

Write-port scheduler for the 8 x 8-bit register file. Two producers share the file's single write port, for example an ALU writeback and a load unit. After reset, or on request, the block first sweeps every register to zero. It then arbitrates the two producers round-robin and drives registered write strobes into the register file's write port.

## Interface
Parameters:
- NUM_REGS, 8, number of registers in the file
- REG_ID_W, 3, register index width; must equal clog2(NUM_REGS)
- DATA_W, 8, register data width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- clear  in  1  in RUN, high for one cycle starts a zero-sweep of all registers
- a_valid  in  1  requester A has a write pending
- a_ready  out  1  requester A write accepted this cycle
- a_reg_id  in  REG_ID_W  requester A target register
- a_reg_val  in  DATA_W  requester A write data
- b_valid, b_ready, b_reg_id, b_reg_val: same as A, for requester B
- rf_write_enable  out  1  registered write strobe to the register file
- rf_write_reg_id  out  REG_ID_W  registered write index
- rf_write_reg_val  out  DATA_W  registered write data
- init_done  out  1  high while in RUN

## Operation
States:
- ST_INIT: sweeps all registers to zero.
  - Each cycle loads the output registers with (1, sweep_cnt, 0) and increments sweep_cnt.
  - After the cycle with sweep_cnt == NUM_REGS-1, goes to ST_RUN and clears sweep_cnt.
  - a_ready and b_ready are low throughout.
- ST_RUN: arbitrates the two requesters.
  - Grant, combinational:
    - only one valid: that requester wins;
    - both valid: the requester named by prio wins.
  - x_ready = granted_x && !clear. No ready without the matching valid.
  - A transfer occurs on x_valid && x_ready. At the next edge:
    - output registers load (1, x_reg_id, x_reg_val);
    - prio moves to the other requester.
  - No transfer: rf_write_enable loads 0; id and val hold their previous values.
  - clear high: no grant that cycle; goes to ST_INIT at the next edge.

Requester rules:
- Once x_valid is asserted, x_reg_id and x_reg_val stay stable until the transfer.
- The scheduler does not check for violations.

Other rules:
- Same-id writes from A and B are serialized in grant order; the last granted write wins.
- Reset values:
  - state = ST_INIT, sweep_cnt = 0, prio = A;
  - rf_write_enable = 0, rf_write_reg_id = 0, rf_write_reg_val = 0;
  - init_done = 0; a_ready and b_ready are 0.
- init_done is registered. It is 1 exactly while state == ST_RUN.

## Timing
- Latency from an accepted request to the register-file write strobe:
  - accept in cycle n; rf_write_enable is high during cycle n+1;
  - the register file captures the write at the end of cycle n+1.
- Throughput: one write per cycle. With both valid continuously, grants alternate A, B, A, B.
- Init sweep:
  - the first INIT cycle after reset deasserts is cycle 0;
  - writes are visible on the outputs during cycles 1..NUM_REGS;
  - init_done rises at the start of cycle NUM_REGS;
  - the first grant is possible in cycle NUM_REGS.
- clear handling:
  - clear in INIT is ignored; the sweep continues;
  - clear in the same cycle as valid: no accept; the requester keeps valid asserted.
- Reset asserted at any cycle (mid-sweep or mid-run), applied at that edge:
  - state returns to ST_INIT, sweep restarts at 0;
  - outputs return to reset values; any pending output write is dropped.

## Structure
- Package regfile_pkg holds:
  - NUM_REGS, REG_ID_W, DATA_W constants;
  - state typedef {ST_INIT, ST_RUN};
  - requester-select typedef {SEL_A, SEL_B}, used for prio.
- Sub-module rr_arb2 holds the arbitration:
  - inputs: two valids, prio, enable;
  - outputs: one-hot grant;
  - purely combinational.
- The top level holds the FSM, sweep_cnt, prio update and output registers.

## Test plan
- Reset, then idle for 10 cycles:
  - outputs show writes (1,0,0) through (1,7,0) on cycles 1..8;
  - init_done = 1 from cycle 8;
  - no ready during the sweep.
- In RUN, a_valid alone with (3, 0xFF):
  - a_ready = 1 in the same cycle;
  - next cycle rf_write = (1, 3, 0xFF);
  - the following cycle rf_write_enable = 0.
- A and B valid for 4 cycles, A=(1,0x11), B=(2,0x22), prio=A:
  - grants A, B, A, B;
  - outputs (1,0x11), (2,0x22), (1,0x11), (2,0x22) on successive cycles.
- Both requesters write register 5: A=0xAA, B=0xBB, prio=B:
  - B is granted first, then A;
  - a register-file model reads 0xAA at the end.
- clear pulsed with a_valid high:
  - a_ready = 0;
  - next cycle init_done = 0 and the 8-cycle zero sweep runs;
  - A is accepted in the first RUN cycle.
- reset asserted at sweep_cnt = 4:
  - all outputs return to 0 at the next edge;
  - the sweep restarts at register 0.
